// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard sizing, functional-unit tags, exception and
// scoreboard entry layouts.
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef enum logic [2:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0] pc;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        use_imm;
    logic        in_flight;
    exception    ex;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order issue/commit buffer with out-of-order writeback by transaction id.
// Flush takes priority over every other update in the same cycle.
module scoreboard
  import ariane_pkg::NR_SB_ENTRIES;
  import ariane_pkg::scoreboard_entry;
  import ariane_pkg::exception;
#(
  parameter int unsigned NR_ENTRIES    = NR_SB_ENTRIES,
  parameter int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic [31:0]              rd_clobber_o,
  input  scoreboard_entry          decoded_instr_i,
  input  logic                     decoded_instr_valid_i,
  output logic                     decoded_instr_ack_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  input  logic                     wb_valid_i,
  input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [63:0]              wb_data_i,
  input  exception                 wb_ex_i,
  output scoreboard_entry          commit_instr_o,
  output logic                     commit_valid_o,
  input  logic                     commit_ack_i
);

  localparam logic [TRANS_ID_BITS:0] FULL_COUNT = NR_ENTRIES[TRANS_ID_BITS:0];

  scoreboard_entry            mem_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0]   head_q, tail_q;
  logic [TRANS_ID_BITS:0]     count_q, count_d;
  logic                       do_commit;
  scoreboard_entry            issue_entry;

  always_comb begin
    full_o              = (count_q == FULL_COUNT);
    decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
    trans_id_o          = tail_q;
    commit_instr_o      = mem_q[head_q];
    commit_valid_o      = mem_q[head_q].valid & ~mem_q[head_q].in_flight;
    do_commit           = commit_ack_i & commit_valid_o;

    // Exceptions raised at decode need no FU, so the entry is born finished.
    issue_entry           = decoded_instr_i;
    issue_entry.valid     = 1'b1;
    issue_entry.result    = '0;
    issue_entry.in_flight = ~decoded_instr_i.ex.valid;

    count_d = count_q;
    case ({decoded_instr_ack_o, do_commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rd_clobber_o = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      if (mem_q[i].valid) rd_clobber_o[mem_q[i].rd] = 1'b1;
    end
    rd_clobber_o[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i].valid <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (decoded_instr_ack_o) begin
        mem_q[tail_q] <= issue_entry;
        tail_q        <= tail_q + 1'b1;
      end
      if (wb_valid_i && mem_q[wb_trans_id_i].valid) begin
        mem_q[wb_trans_id_i].result    <= wb_data_i;
        mem_q[wb_trans_id_i].in_flight <= 1'b0;
        if (wb_ex_i.valid) mem_q[wb_trans_id_i].ex <= wb_ex_i;
      end
      if (do_commit) begin
        mem_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule
